sram_loader: RTL and testbench
==============================

SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 Parameter WE_CYCLES, default 2: number of clock cycles sram_WE is held low per word write (1..15).
REQ-002 Parameter LAST_ADDR, default 18'h3FFFF: highest SRAM word address the loader may write.
REQ-003 clk  input  1  single 50 MHz system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse; begins a load at address 0.
REQ-006 in_data  input  8  program byte; low byte of each word first.
REQ-007 in_valid  input  1  in_data/in_last valid.
REQ-008 in_last  input  1  qualifies the final byte of the program.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 sram_WE, sram_CE, sram_OE, sram_LB, sram_UB  output  1 each  active-low SRAM controls.
REQ-011 sram_addr  output  18  SRAM word address.
REQ-012 sram_dout  output  16  write data to SRAM I/O.
REQ-013 sram_dout_en  output  1  tri-state enable for SRAM I/O (1 = loader drives bus).
REQ-014 busy  output  1  high in any state except IDLE and DONE.
REQ-015 done  output  1  load finished; held until next start or reset.
REQ-016 overflow  output  1  bytes offered after LAST_ADDR was written without in_last.

Function
REQ-017 The FSM SHALL have states IDLE, LO, HI, SETUP, WRITE, HOLD, DONE.
REQ-018 A byte SHALL transfer on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LO and HI.
REQ-019 IDLE/DONE + start=1 -> LO; sram_addr := 0; done, overflow := 0.
REQ-020 start SHALL be ignored in LO, HI, SETUP, WRITE, HOLD.
REQ-021 LO transfer: in_data -> sram_dout[7:0]; in_last=0 -> HI; in_last=1 -> SETUP with sram_dout[15:8]=8'h00 and UB-skip flag set.
REQ-022 HI transfer: in_data -> sram_dout[15:8] -> SETUP; in_last captured as the last-word flag.
REQ-023 SETUP (1 cycle): sram_CE=0, sram_dout_en=1, sram_WE=1, sram_LB=0, sram_UB=0 (1 if UB-skip), address and data stable.
REQ-024 WRITE (exactly WE_CYCLES cycles, internal 4-bit counter): sram_WE=0, all other SETUP outputs unchanged.
REQ-025 HOLD (1 cycle): sram_WE=1; address, data, CE, LB/UB, dout_en unchanged.
REQ-026 HOLD exit: last-word flag -> DONE; else sram_addr=LAST_ADDR -> DONE with overflow=1 if the next byte is offered (in_valid=1) in DONE before start; else sram_addr+1 -> LO.
REQ-027 One word write SHALL occupy WE_CYCLES+2 cycles from SETUP entry to HOLD exit; sram_WE falls on the second cycle after the high-byte transfer.
REQ-028 sram_addr SHALL never wrap; it stays at LAST_ADDR in DONE.
REQ-029 sram_OE SHALL be 1 at all times; sram_CE and sram_dout_en SHALL be inactive (1, 0) in IDLE, LO, HI, DONE.
REQ-030 sram_addr and sram_dout SHALL change only in IDLE/LO/HI, never while sram_WE=0.
REQ-031 done SHALL rise on the cycle of entering DONE; busy=0 in DONE.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, sram_WE=CE=OE=LB=UB=1, sram_addr=0, sram_dout=0, sram_dout_en=0, in_ready=0, busy=0, done=0, overflow=0.
REQ-033 Reset asserted mid-WRITE SHALL release sram_WE high asynchronously; no write resumes after rst_n returns high.

Verification
REQ-034 start, bytes 34,12,78,56(last) -> addr 0 gets 16'h1234, addr 1 gets 16'h5678, WE low 2 cycles each, done=1, sram_addr=1.
REQ-035 start, bytes AB, CD(last)... single byte AB(last) -> addr 0 write with LB=0, UB=1, sram_dout=16'h00AB, done=1.
REQ-036 in_valid held 1 continuously with 6 bytes -> in_ready=0 during SETUP/WRITE/HOLD, 3 words written, 4 cycles per word plus 2 byte cycles.
REQ-037 LAST_ADDR=18'd1, 6 bytes, no in_last -> 2 words written, DONE, 5th byte offered -> overflow=1, addr stays 1.
REQ-038 rst_n low on 2nd WRITE cycle -> sram_WE=1, CE=1, dout_en=0 same cycle, done=0; new start writes from addr 0.
REQ-039 start pulsed while busy -> ignored, address sequence unchanged; start in DONE -> done and overflow cleared, addr 0.

Source files
------------

// File: rtl/sram_loader.sv
`default_nettype none
// ============================================================================
// Module      : sram_loader
// Description : Streams a byte-wide program into a 16-bit asynchronous SRAM.
//               Bytes arrive low byte first and are paired into words. Each
//               word is written with a setup cycle, a WE_CYCLES-long write
//               strobe and a hold cycle. A single trailing byte is written
//               with the upper byte lane masked.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_loader #(
  parameter int unsigned WE_CYCLES = 2,
  parameter logic [17:0] LAST_ADDR = 18'h3FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        sram_WE,
  output logic        sram_CE,
  output logic        sram_OE,
  output logic        sram_LB,
  output logic        sram_UB,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dout,
  output logic        sram_dout_en,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  // Terminal value of the write-strobe counter (counts 0 .. WE_CYCLES-1).
  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_SETUP = 3'd3,
    S_WRITE = 3'd4,
    S_HOLD  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        ub_skip_q, ub_skip_d;    // upper byte lane masked for this word
  logic        last_q, last_d;          // current word holds the final byte
  logic [3:0]  we_cnt_q, we_cnt_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        ovf_arm_q, ovf_arm_d;    // DONE was reached by address exhaustion

  logic        w_xfer;
  logic        w_active;

  // A byte moves only when the loader is collecting bytes and data is offered.
  assign w_xfer = in_valid & in_ready;

  // Next-state and datapath updates; addr/data only move in IDLE/LO/HI/HOLD-exit.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    ub_skip_d = ub_skip_q;
    last_d    = last_q;
    we_cnt_d  = we_cnt_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    ovf_arm_d = ovf_arm_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LO;
          addr_d    = '0;
          done_d    = 1'b0;
          ovf_d     = 1'b0;
          ovf_arm_d = 1'b0;
          ub_skip_d = 1'b0;
          last_d    = 1'b0;
        end else if ((state_q == S_DONE) && ovf_arm_q && in_valid) begin
          // Data offered after the address space ran out is lost.
          ovf_d = 1'b1;
        end
      end

      S_LO: begin
        if (w_xfer) begin
          dout_d[7:0] = in_data;
          if (in_last) begin
            dout_d[15:8] = 8'h00;
            ub_skip_d    = 1'b1;
            last_d       = 1'b1;
            state_d      = S_SETUP;
          end else begin
            ub_skip_d = 1'b0;
            last_d    = 1'b0;
            state_d   = S_HI;
          end
        end
      end

      S_HI: begin
        if (w_xfer) begin
          dout_d[15:8] = in_data;
          last_d       = in_last;
          state_d      = S_SETUP;
        end
      end

      S_SETUP: begin
        we_cnt_d = '0;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        if (we_cnt_q == WE_LAST) begin
          state_d = S_HOLD;
        end else begin
          we_cnt_d = we_cnt_q + 4'd1;
        end
      end

      S_HOLD: begin
        if (last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          // Never wrap: park on the final address and watch for excess data.
          state_d   = S_DONE;
          done_d    = 1'b1;
          ovf_arm_d = 1'b1;
        end else begin
          addr_d  = addr_q + 18'd1;
          state_d = S_LO;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops every SRAM control inactive at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      dout_q    <= '0;
      ub_skip_q <= 1'b0;
      last_q    <= 1'b0;
      we_cnt_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_arm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      ub_skip_q <= ub_skip_d;
      last_q    <= last_d;
      we_cnt_q  <= we_cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      ovf_arm_q <= ovf_arm_d;
    end
  end

  // Output decode straight from the state register so reset acts immediately.
  always_comb begin
    w_active     = (state_q == S_SETUP) || (state_q == S_WRITE) || (state_q == S_HOLD);
    in_ready     = (state_q == S_LO) || (state_q == S_HI);
    sram_WE      = (state_q != S_WRITE);
    sram_CE      = ~w_active;
    sram_OE      = 1'b1;
    sram_LB      = ~w_active;
    sram_UB      = ~w_active | ub_skip_q;
    sram_dout_en = w_active;
    sram_addr    = addr_q;
    sram_dout    = dout_q;
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    done         = done_q;
    overflow     = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_loader
// Description : Scoreboard bench for sram_loader. Two instances: default
//               parameters, and a tiny address space with a longer strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_loader;

  localparam int unsigned D0_WE   = 2;
  localparam int unsigned D1_WE   = 3;
  localparam logic [17:0] D0_LAST = 18'h3FFFF;
  localparam logic [17:0] D1_LAST = 18'd1;

  typedef logic [7:0] u8_t;
  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
    logic        ub;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic [1:0]  rdy, we, ce, oe, lb, ub, den, bsy, dn, ovf;
  logic [17:0] addr_w [2];
  logic [15:0] dout_w [2];

  int sel = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  wr_t exp_q[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_loader #(.WE_CYCLES(D0_WE), .LAST_ADDR(D0_LAST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[0]),
    .sram_WE(we[0]), .sram_CE(ce[0]), .sram_OE(oe[0]), .sram_LB(lb[0]),
    .sram_UB(ub[0]), .sram_addr(addr_w[0]), .sram_dout(dout_w[0]),
    .sram_dout_en(den[0]), .busy(bsy[0]), .done(dn[0]), .overflow(ovf[0])
  );

  sram_loader #(.WE_CYCLES(D1_WE), .LAST_ADDR(D1_LAST)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[1]),
    .sram_WE(we[1]), .sram_CE(ce[1]), .sram_OE(oe[1]), .sram_LB(lb[1]),
    .sram_UB(ub[1]), .sram_addr(addr_w[1]), .sram_dout(dout_w[1]),
    .sram_dout_en(den[1]), .busy(bsy[1]), .done(dn[1]), .overflow(ovf[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor: pops expected writes on each WE fall -----------
  logic        m_prev_we = 1'b1;
  logic        m_inw = 1'b0;
  int          m_len = 0;
  logic [17:0] m_addr;
  logic [15:0] m_dout;
  wr_t         m_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev_we = 1'b1;
      m_inw     = 1'b0;
    end else begin
      check("oe_high", {31'd0, oe[sel]}, 32'd1);
      check("ready_excl_ce", {31'd0, rdy[sel] & ~ce[sel]}, 32'd0);
      if (m_prev_we && !we[sel]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", addr_w[sel], dout_w[sel]);
        end else begin
          m_exp = exp_q.pop_front();
          check("wr_addr", {14'd0, addr_w[sel]}, {14'd0, m_exp.addr});
          check("wr_data", {16'd0, dout_w[sel]}, {16'd0, m_exp.data});
          check("wr_ub", {31'd0, ub[sel]}, {31'd0, m_exp.ub});
          check("wr_lb", {31'd0, lb[sel]}, 32'd0);
          check("wr_ce", {31'd0, ce[sel]}, 32'd0);
          check("wr_dout_en", {31'd0, den[sel]}, 32'd1);
        end
        m_inw  = 1'b1;
        m_len  = 1;
        m_addr = addr_w[sel];
        m_dout = dout_w[sel];
      end else if (m_inw && !we[sel]) begin
        m_len++;
        check("addr_stable_we_low", {14'd0, addr_w[sel]}, {14'd0, m_addr});
        check("dout_stable_we_low", {16'd0, dout_w[sel]}, {16'd0, m_dout});
      end else if (m_inw && we[sel]) begin
        check("we_low_cycles", m_len, (sel == 1) ? D1_WE : D0_WE);
        check("hold_ce", {31'd0, ce[sel]}, 32'd0);
        m_inw = 1'b0;
      end
      m_prev_we = we[sel];
    end
  end

  // ---------------- reference model: byte stream -> expected writes --------
  function automatic void model(input u8_t b[$], input bit lastf, input logic [17:0] la,
                                output int consumed, output logic [17:0] fin_addr);
    logic [17:0] a = '0;
    int i = 0;
    int n = b.size();
    while (1) begin
      if (lastf && i == n - 1) begin
        exp_q.push_back('{addr: a, data: {8'h00, b[i]}, ub: 1'b1});
        i++;
        break;
      end
      exp_q.push_back('{addr: a, data: {b[i+1], b[i]}, ub: 1'b0});
      i += 2;
      if (lastf && i == n) break;
      if (a == la) break;
      a++;
    end
    consumed = i;
    fin_addr = a;
  endfunction

  // ---------------- stimulus ----------------------------------------------
  task automatic do_reset(input int which);
    @(negedge clk);
    rst_n = 1'b0;
    sel = which;
    #1;
    check("rst_we", {31'd0, we[sel]}, 32'd1);
    check("rst_ce", {31'd0, ce[sel]}, 32'd1);
    check("rst_lb_ub", {30'd0, lb[sel], ub[sel]}, 32'd3);
    check("rst_addr", {14'd0, addr_w[sel]}, 32'd0);
    check("rst_dout", {16'd0, dout_w[sel]}, 32'd0);
    check("rst_flags", {26'd0, den[sel], rdy[sel], bsy[sel], dn[sel], ovf[sel], oe[sel]}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic send(input u8_t b[$], input int n, input bit lastf, input int maxgap);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b[i];
      in_last  = lastf && (i == b.size() - 1);
      t = 0;
      while (rdy[sel] !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("byte_accepted", {31'd0, t < 200}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_done(output int t);
    t = 0;
    while (dn[sel] !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", {31'd0, t < 500}, 32'd1);
  endtask

  task automatic run_load(input u8_t b[$], input bit lastf, input int maxgap, output int cycles);
    int consumed, s, t;
    logic [17:0] fin;
    model(b, lastf, (sel == 1) ? D1_LAST : D0_LAST, consumed, fin);
    pulse_start(s);
    send(b, consumed, lastf, maxgap);
    wait_done(t);
    cycles = cyc - s;
    check("end_done", {31'd0, dn[sel]}, 32'd1);
    check("end_busy", {31'd0, bsy[sel]}, 32'd0);
    check("end_addr", {14'd0, addr_w[sel]}, {14'd0, fin});
    check("end_overflow", {31'd0, ovf[sel]}, 32'd0);
    check("pending_writes", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u8_t b[$];
    int cycles, t, consumed, s;
    logic [17:0] fin;

    // Two full words, fixed data.
    do_reset(0);
    b = {8'h34, 8'h12, 8'h78, 8'h56};
    run_load(b, 1'b1, 2, cycles);

    // Single trailing byte masks the upper lane.
    b = {8'hAB};
    run_load(b, 1'b1, 1, cycles);

    // Continuous valid: each word costs two byte cycles plus the write cycle.
    b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load(b, 1'b1, 0, cycles);
    check("continuous_cycles", cycles, 3 * (D0_WE + 4));

    // Random programs with random gaps.
    for (int k = 0; k < 6; k++) begin
      b = {};
      for (int j = 0; j < $urandom_range(1, 9); j++) b.push_back(u8_t'($urandom));
      run_load(b, 1'b1, 2, cycles);
    end

    // Start pulses while busy must not disturb the address sequence.
    b = {};
    for (int j = 0; j < 8; j++) b.push_back(u8_t'($urandom));
    fork
      run_load(b, 1'b1, 0, cycles);
      begin
        for (int p = 0; p < 3; p++) begin
          repeat (5) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join

    // Reset in the second WRITE cycle aborts the write immediately.
    b = {8'h11, 8'h22, 8'h33, 8'h44};
    model(b, 1'b1, D0_LAST, consumed, fin);
    pulse_start(s);
    send(b, 2, 1'b1, 0);
    t = 0;
    while (we[sel] !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("we_fell", {31'd0, we[sel]}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_we", {31'd0, we[sel]}, 32'd1);
    check("abort_ce", {31'd0, ce[sel]}, 32'd1);
    check("abort_dout_en", {31'd0, den[sel]}, 32'd0);
    check("abort_done", {31'd0, dn[sel]}, 32'd0);
    exp_q = {};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_resume_busy", {31'd0, bsy[sel]}, 32'd0);
    b = {8'hC3, 8'h5A, 8'hEE};
    run_load(b, 1'b1, 1, cycles);

    // Address exhaustion on the small instance, then overflow, then restart.
    do_reset(1);
    b = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_load(b, 1'b0, 1, cycles);
    in_valid = 1'b1;
    in_data  = b[4];
    #1;
    check("ovf_not_ready", {31'd0, rdy[sel]}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("ovf_set", {31'd0, ovf[sel]}, 32'd1);
    check("ovf_addr", {14'd0, addr_w[sel]}, 32'd1);
    check("ovf_done", {31'd0, dn[sel]}, 32'd1);
    pulse_start(s);
    check("restart_done", {31'd0, dn[sel]}, 32'd0);
    check("restart_ovf", {31'd0, ovf[sel]}, 32'd0);
    check("restart_addr", {14'd0, addr_w[sel]}, 32'd0);
    check("restart_busy", {31'd0, bsy[sel]}, 32'd1);
    exp_q = {};
    do_reset(0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
